// File: rtl/cell_sweep_reader.sv
`default_nettype none
// ============================================================================
// Module      : cell_sweep_reader
// Description : Steps a 6-bit stimulus from 0 to LAST_STIM. At each step it
//               waits SETTLE_CYCLES, captures the 73-bit cell-array response
//               and streams it out as an 11-byte valid/ready frame.
//               Optional MISR signature over all captures: define
//               CELL_SWEEP_MISR_EN to add sig_o[31:0].
// Revision    : 1.0 - initial release
// ============================================================================
module cell_sweep_reader #(
  parameter int SETTLE_CYCLES = 4,
  parameter int LAST_STIM     = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [5:0]  stim_o,
  input  logic [72:0] resp_i,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
`ifdef CELL_SWEEP_MISR_EN
  output logic [31:0] sig_o,
`endif
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] c_LAST      = 6'(LAST_STIM);
  localparam logic [7:0] c_SETTLE_M1 = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] c_LAST_BYTE = 4'd10;

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_idx;
  logic [72:0] r_cap;
  logic [5:0]  r_stim;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic        w_sweep_start;
  logic        w_capture;
  logic        w_accept;
  logic [72:0] w_shift;
  logic [7:0]  w_next_byte;

  // Sweep launch, response sampling and byte handshake qualifiers.
  always_comb begin
    w_sweep_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    w_capture     = (r_state == S_DRIVE) && (r_cnt == 8'd0);
    w_accept      = (r_state == S_SEND) && r_tx_valid && tx_ready;
  end

  // Byte following the one currently presented: frame byte (r_idx+1) is the
  // capture shifted down by 8*r_idx; byte 10 naturally yields {7'b0, cap[72]}.
  always_comb begin
    w_shift     = r_cap >> {r_idx, 3'b000};
    w_next_byte = w_shift[7:0];
  end

  // Main sweep state machine: settle, capture, then frame out the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_idx      <= 4'd0;
      r_cap      <= '0;
      r_stim     <= 6'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_sweep_start) begin
            r_state <= S_DRIVE;
            r_stim  <= 6'd0;
            r_cnt   <= c_SETTLE_M1;
          end
        end
        S_DRIVE: begin
          if (w_capture) begin
            r_cap      <= resp_i;
            r_state    <= S_SEND;
            r_idx      <= 4'd0;
            r_tx_data  <= {2'b10, r_stim};
            r_tx_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (r_idx == c_LAST_BYTE) begin
              r_tx_valid <= 1'b0;
              r_idx      <= 4'd0;
              if (r_stim == c_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_stim  <= r_stim + 6'd1;
                r_state <= S_DRIVE;
                r_cnt   <= c_SETTLE_M1;
              end
            end else begin
              r_idx     <= r_idx + 4'd1;
              r_tx_data <= w_next_byte;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CELL_SWEEP_MISR_EN
  logic [31:0] r_sig;
  logic [31:0] w_fold;
  logic [31:0] w_sig_nx;

  // CRC-32 polynomial MISR step folding the 73-bit response into 32 bits.
  always_comb begin
    w_fold   = resp_i[31:0] ^ resp_i[63:32] ^ {23'b0, resp_i[72:64]};
    w_sig_nx = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? 32'h04C11DB7 : 32'h0) ^ w_fold;
  end

  // Signature seeds on sweep start and absorbs every captured response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= 32'hFFFFFFFF;
    end else if (w_sweep_start) begin
      r_sig <= 32'hFFFFFFFF;
    end else if (w_capture) begin
      r_sig <= w_sig_nx;
    end
  end

  assign sig_o = r_sig;
`endif

  assign stim_o   = r_stim;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = (r_state == S_DRIVE) || (r_state == S_SEND);
  assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cell_sweep_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_sweep_reader
// Description : Directed self-checking bench for cell_sweep_reader. Three
//               instances: default parameters, SETTLE_CYCLES=3, LAST_STIM=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_sweep_reader;

  logic clk;
  int   checks;
  int   errors;

  // Instance A: defaults (SETTLE_CYCLES=4, LAST_STIM=63)
  logic        rst_a, start_a, ready_a;
  logic [5:0]  stim_a;
  logic [72:0] resp_a;
  logic [7:0]  data_a;
  logic        valid_a, busy_a, done_a;
  // Instance B: SETTLE_CYCLES=3
  logic        rst_b, start_b, ready_b;
  logic [5:0]  stim_b;
  logic [72:0] resp_b;
  logic [7:0]  data_b;
  logic        valid_b, busy_b, done_b;
  // Instance C: LAST_STIM=0, zero response
  logic        rst_c, start_c, ready_c;
  logic [5:0]  stim_c;
  logic [72:0] resp_c;
  logic [7:0]  data_c;
  logic        valid_c, busy_c, done_c;
`ifdef CELL_SWEEP_MISR_EN
  logic [31:0] sig_a, sig_b, sig_c;
`endif

  // Response model: stimulus replicated twelve times, topped with stim[0].
  function automatic logic [72:0] resp_model(input logic [5:0] s);
    return {s[0], {12{s}}};
  endfunction

  function automatic logic [7:0] exp_byte(input int f, input int b);
    logic [72:0] r;
    logic [5:0]  s;
    s = f[5:0];
    r = resp_model(s);
    if (b == 0)       return {2'b10, s};
    else if (b == 10) return {7'b0, r[72]};
    else              return r[8*(b-1) +: 8];
  endfunction

  assign resp_a = resp_model(stim_a);
  // After capture the response is inverted so a late sample would show up.
  assign resp_b = valid_b ? ~resp_model(stim_b) : resp_model(stim_b);
  assign resp_c = '0;

  cell_sweep_reader u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stim_o(stim_a), .resp_i(resp_a),
    .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a), .busy(busy_a),
`ifdef CELL_SWEEP_MISR_EN
    .sig_o(sig_a),
`endif
    .done(done_a)
  );

  cell_sweep_reader #(.SETTLE_CYCLES(3), .LAST_STIM(63)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stim_o(stim_b), .resp_i(resp_b),
    .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b), .busy(busy_b),
`ifdef CELL_SWEEP_MISR_EN
    .sig_o(sig_b),
`endif
    .done(done_b)
  );

  cell_sweep_reader #(.SETTLE_CYCLES(4), .LAST_STIM(0)) u_dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .stim_o(stim_c), .resp_i(resp_c),
    .tx_data(data_c), .tx_valid(valid_c), .tx_ready(ready_c), .busy(busy_c),
`ifdef CELL_SWEEP_MISR_EN
    .sig_o(sig_c),
`endif
    .done(done_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on instance A. abort_frame >= 0 asserts rst at byte 5 of it.
  task automatic run_sweep_a(input int pct, input int abort_frame);
    int       frame;
    int       bi;
    int       cyc;
    logic     prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp;
    frame = 0; bi = 0; cyc = 0; prev_stall = 1'b0; prev_data = 8'h00;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    while (frame < 64 && cyc < 20000) begin
      ready_a = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (prev_stall) begin
        checks++;
        if (valid_a !== 1'b1 || data_a !== prev_data) begin
          errors++;
          $display("FAIL stall_hold frame %0d byte %0d: valid=%b data=%h required valid=1 data=%h",
                   frame, bi, valid_a, data_a, prev_data);
        end
      end
      if (valid_a === 1'b1 && ready_a) begin
        exp = exp_byte(frame, bi);
        checks++;
        if (data_a !== exp) begin
          errors++;
          $display("FAIL sweep_byte frame %0d byte %0d: got %h required %h", frame, bi, data_a, exp);
        end
        if (frame == abort_frame && bi == 5) begin
          rst_a = 1'b1;
          tick();
          rst_a = 1'b0;
          checks++;
          if (stim_a !== 6'd0 || valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: stim=%h valid=%b busy=%b done=%b required 0 0 0 0",
                     stim_a, valid_a, busy_a, done_a);
          end
          return;
        end
        bi++;
        if (bi == 11) begin
          bi = 0;
          frame++;
        end
      end
      prev_stall = (valid_a === 1'b1) && !ready_a;
      prev_data  = data_a;
      tick();
      cyc++;
    end
    ready_a = 1'b1;
    checks++;
    if (frame * 11 + bi != 704) begin
      errors++;
      $display("FAIL sweep_count: got %0d bytes required 704", frame * 11 + bi);
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0 || stim_a !== 6'd63) begin
      errors++;
      $display("FAIL sweep_end: done=%b busy=%b valid=%b stim=%h required 1 0 0 3f",
               done_a, busy_a, valid_a, stim_a);
    end
    repeat (4) begin
      tick();
      checks++;
      if (valid_a !== 1'b0 || done_a !== 1'b1) begin
        errors++;
        $display("FAIL sweep_extra: valid=%b done=%b required 0 1", valid_a, done_a);
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (3) tick();
    checks++;
    if (stim_a !== 6'd0 || data_a !== 8'd0 || valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: stim=%h data=%h valid=%b busy=%b done=%b required all 0",
               stim_a, data_a, valid_a, busy_a, done_a);
    end
    checks++;
    if (busy_c !== 1'b0 || valid_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: busy=%b valid=%b required 0 0", busy_c, valid_c);
    end
`ifdef CELL_SWEEP_MISR_EN
    checks++;
    if (sig_a !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_sig: got %h required ffffffff", sig_a);
    end
`endif
    start_c = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b valid=%b required 0 0 0", busy_a, done_a, valid_a);
    end
  endtask

  task automatic test_full_sweep();
    run_sweep_a(100, -1);
  endtask

  task automatic test_backpressure();
    run_sweep_a(30, -1);
  endtask

  task automatic test_reset_mid_sweep();
    run_sweep_a(100, 12);
    tick();
    run_sweep_a(100, -1);
  endtask

  task automatic test_settle_timing();
    int n;
    int hold;
    logic [7:0] exp;
    ready_b = 1'b1;
    start_b = 1'b1;
    n = 0;
    // start is high during cycle 1; three settle cycles follow.
    while (valid_b !== 1'b1 && n < 20) begin
      tick();
      start_b = 1'b0;
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d cycles required 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 11; b++) begin
        exp = exp_byte(k, b);
        checks++;
        if (valid_b !== 1'b1 || data_b !== exp) begin
          errors++;
          $display("FAIL settle_frame %0d byte %0d: valid=%b data=%h required valid=1 data=%h",
                   k, b, valid_b, data_b, exp);
        end
        tick();
      end
      if (k < 3) begin
        hold = 0;
        while (valid_b !== 1'b1 && hold < 20) begin
          checks++;
          if (stim_b !== 6'(k + 1) || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL settle_stim frame %0d: stim=%h busy=%b required %h 1", k + 1, stim_b, busy_b, 6'(k + 1));
          end
          hold++;
          tick();
        end
        checks++;
        if (hold != 3) begin
          errors++;
          $display("FAIL settle_hold frame %0d: got %0d cycles required 3", k + 1, hold);
        end
      end
    end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
  endtask

  task automatic test_single_step();
    int n;
    logic [7:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      start_c = 1'b1;
      n = 0;
      while (valid_c !== 1'b1 && n < 20) begin
        tick();
        if (pass == 1) start_c = 1'b0;
        n++;
      end
      for (int b = 0; b < 11; b++) begin
        if (b == 10) start_c = 1'b0;
        exp = (b == 0) ? 8'h80 : 8'h00;
        checks++;
        if (valid_c !== 1'b1 || data_c !== exp) begin
          errors++;
          $display("FAIL single_frame pass %0d byte %0d: valid=%b data=%h required valid=1 data=%h",
                   pass, b, valid_c, data_c, exp);
        end
        tick();
      end
      checks++;
      if (done_c !== 1'b1 || busy_c !== 1'b0 || valid_c !== 1'b0 || stim_c !== 6'd0) begin
        errors++;
        $display("FAIL single_done pass %0d: done=%b busy=%b valid=%b stim=%h required 1 0 0 00",
                 pass, done_c, busy_c, valid_c, stim_c);
      end
`ifdef CELL_SWEEP_MISR_EN
      checks++;
      if (sig_c !== 32'hFB3EE249) begin
        errors++;
        $display("FAIL misr_sig pass %0d: got %h required fb3ee249", pass, sig_c);
      end
`endif
      repeat (3) begin
        tick();
        checks++;
        if (valid_c !== 1'b0 || done_c !== 1'b1) begin
          errors++;
          $display("FAIL single_extra pass %0d: valid=%b done=%b required 0 1", pass, valid_c, done_c);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_sweep();
    test_settle_timing();
    test_backpressure();
    test_reset_mid_sweep();
    test_single_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
